// File: rtl/mcpu5_sequencer.sv
// Host-side sequencer for the MCPU5 pin interface: program RAM, CPU clock/reset generation,
// instruction feed, OUT capture FIFO, and run/stop/step/breakpoint control.
module mcpu5_sequencer #(
    parameter int HALF       = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int RST_CYC    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic        step,
    input  logic        bp_en,
    input  logic [7:0]  bp_addr,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [7:0]  ld_addr,
    input  logic [5:0]  ld_data,
    output logic        cpu_clk,
    output logic        cpu_rst,
    output logic [5:0]  cpu_inst,
    input  logic [7:0]  cpu_out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        halted,
    output logic        busy,
    output logic [7:0]  pc_mon,
    output logic [15:0] icount
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [5:0] OUT_OP = 6'b111011;

    typedef enum logic [2:0] {IDLE, CRST, LO, HI, FETCH, HALT} state_t;

    state_t      state_reg, state_next;
    logic [7:0]  phase_reg, phase_next;
    logic [7:0]  crst_cnt_reg, crst_cnt_next;
    logic        cpu_clk_reg, cpu_clk_next;
    logic        cpu_rst_reg, cpu_rst_next;
    logic [5:0]  cpu_inst_reg, cpu_inst_next;
    logic [7:0]  pc_mon_reg, pc_mon_next;
    logic [15:0] icount_reg, icount_next;
    logic        stop_pend_reg, stop_pend_next;
    logic        step_mode_reg, step_mode_next;
    logic        bp_skip_reg, bp_skip_next;
    logic [AW:0] wr_ptr_reg, rd_ptr_reg;

    logic [5:0]  prog_ram [0:255];
    logic [5:0]  ram_q_reg;
    logic [7:0]  fifo_mem [0:FIFO_DEPTH-1];
    logic [7:0]  rd_addr;
    logic        push, pop, fifo_full, phase_last, lo_stall, bp_hit;

    assign ld_ready   = (state_reg == IDLE) || (state_reg == HALT);
    assign halted     = (state_reg == HALT);
    assign busy       = (state_reg == CRST) || (state_reg == LO) ||
                        (state_reg == HI) || (state_reg == FETCH);
    assign cpu_clk    = cpu_clk_reg;
    assign cpu_rst    = cpu_rst_reg;
    assign cpu_inst   = cpu_inst_reg;
    assign pc_mon     = pc_mon_reg;
    assign icount     = icount_reg;

    assign out_valid  = (wr_ptr_reg != rd_ptr_reg);
    assign out_data   = fifo_mem[rd_ptr_reg[AW-1:0]];
    assign pop        = out_valid && out_ready;
    assign fifo_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                        (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign phase_last = (phase_reg == 8'(HALF - 1));
    // A pop in the same cycle frees the slot, so a full FIFO only stalls without one.
    assign lo_stall   = (cpu_inst_reg == OUT_OP) && fifo_full && !pop;
    assign bp_hit     = bp_en && (pc_mon_reg == bp_addr) && !bp_skip_reg;

    // Program RAM: write port from the loader, registered read for the fetch path.
    always_ff @(posedge clk) begin
        if (ld_valid && ld_ready)
            prog_ram[ld_addr] <= ld_data;
        ram_q_reg <= prog_ram[rd_addr];
    end

    generate
        for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_fifo
            always_ff @(posedge clk) begin
                if (push && (wr_ptr_reg[AW-1:0] == AW'(gi)))
                    fifo_mem[gi] <= cpu_out;
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            phase_reg     <= '0;
            crst_cnt_reg  <= '0;
            cpu_clk_reg   <= 1'b0;
            cpu_rst_reg   <= 1'b1;
            cpu_inst_reg  <= '0;
            pc_mon_reg    <= '0;
            icount_reg    <= '0;
            stop_pend_reg <= 1'b0;
            step_mode_reg <= 1'b0;
            bp_skip_reg   <= 1'b0;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
        end else begin
            state_reg     <= state_next;
            phase_reg     <= phase_next;
            crst_cnt_reg  <= crst_cnt_next;
            cpu_clk_reg   <= cpu_clk_next;
            cpu_rst_reg   <= cpu_rst_next;
            cpu_inst_reg  <= cpu_inst_next;
            pc_mon_reg    <= pc_mon_next;
            icount_reg    <= icount_next;
            stop_pend_reg <= stop_pend_next;
            step_mode_reg <= step_mode_next;
            bp_skip_reg   <= bp_skip_next;
            wr_ptr_reg    <= wr_ptr_reg + (AW+1)'(push);
            rd_ptr_reg    <= rd_ptr_reg + (AW+1)'(pop);
        end
    end

    always_comb begin
        state_next     = state_reg;
        phase_next     = phase_reg;
        crst_cnt_next  = crst_cnt_reg;
        cpu_clk_next   = cpu_clk_reg;
        cpu_rst_next   = cpu_rst_reg;
        cpu_inst_next  = cpu_inst_reg;
        pc_mon_next    = pc_mon_reg;
        icount_next    = icount_reg;
        stop_pend_next = stop_pend_reg || (stop && busy);
        step_mode_next = step_mode_reg;
        bp_skip_next   = bp_skip_reg;
        push           = 1'b0;
        rd_addr        = 8'd0;
        case (state_reg)
            IDLE: begin
                cpu_rst_next = 1'b1;
                cpu_clk_next = 1'b0;
                if (start) begin
                    state_next     = CRST;
                    phase_next     = '0;
                    crst_cnt_next  = '0;
                    icount_next    = '0;
                    stop_pend_next = 1'b0;
                    step_mode_next = 1'b0;
                    bp_skip_next   = 1'b0;
                end
            end
            CRST: begin
                // rd_addr idles at 0, so ram_q_reg already holds the reset vector word.
                cpu_inst_next = ram_q_reg;
                if (phase_last) begin
                    phase_next   = '0;
                    cpu_clk_next = ~cpu_clk_reg;
                    if (crst_cnt_reg == 8'(2 * RST_CYC - 1)) begin
                        cpu_rst_next = 1'b0;
                        pc_mon_next  = '0;
                        state_next   = LO;
                    end else begin
                        crst_cnt_next = crst_cnt_reg + 8'd1;
                    end
                end else begin
                    phase_next = phase_reg + 8'd1;
                end
            end
            LO: begin
                if (!phase_last) begin
                    phase_next = phase_reg + 8'd1;
                end else if (!lo_stall) begin
                    push         = (cpu_inst_reg == OUT_OP);
                    phase_next   = '0;
                    cpu_clk_next = 1'b1;
                    state_next   = HI;
                end
            end
            HI: begin
                if (phase_last) begin
                    pc_mon_next = cpu_out;
                    rd_addr     = cpu_out;
                    phase_next  = '0;
                    state_next  = FETCH;
                end else begin
                    phase_next = phase_reg + 8'd1;
                end
            end
            FETCH: begin
                cpu_inst_next = ram_q_reg;
                icount_next   = icount_reg + 16'd1;
                bp_skip_next  = 1'b0;
                phase_next    = '0;
                if (stop_pend_reg || step_mode_reg || bp_hit) begin
                    stop_pend_next = 1'b0;
                    step_mode_next = 1'b0;
                    state_next     = HALT;
                end else begin
                    cpu_clk_next = 1'b0;
                    state_next   = LO;
                end
            end
            HALT: begin
                if (start || step) begin
                    bp_skip_next   = 1'b1;
                    step_mode_next = !start;
                    cpu_clk_next   = 1'b0;
                    phase_next     = '0;
                    state_next     = LO;
                end
            end
            default: state_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_mcpu5_sequencer.sv
// Directed bench for mcpu5_sequencer with a small behavioural MCPU5 stand-in driving cpu_out.
module tb_mcpu5_sequencer;
    logic        clk = 1'b0;
    logic        rst, start, stop, step, bp_en, ld_valid, out_ready;
    logic [7:0]  bp_addr, ld_addr;
    logic [5:0]  ld_data;
    logic        ld_ready, cpu_clk, cpu_rst, out_valid, halted, busy;
    logic [5:0]  cpu_inst;
    logic [7:0]  cpu_out, out_data, pc_mon;
    logic [15:0] icount;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    mcpu5_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .step(step),
        .bp_en(bp_en), .bp_addr(bp_addr), .ld_valid(ld_valid), .ld_ready(ld_ready),
        .ld_addr(ld_addr), .ld_data(ld_data), .cpu_clk(cpu_clk), .cpu_rst(cpu_rst),
        .cpu_inst(cpu_inst), .cpu_out(cpu_out), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .halted(halted), .busy(busy),
        .pc_mon(pc_mon), .icount(icount)
    );

    always #5 clk = ~clk;

    // CPU stand-in: 01iiii = LDI imm, 00oooo = branch pc+signed offset, others just advance pc.
    logic [7:0] m_pc, m_acc;
    always @(posedge cpu_clk) begin
        if (cpu_rst) begin
            m_pc  <= 8'd0;
            m_acc <= 8'd0;
        end else if (cpu_inst[5:4] == 2'b01) begin
            m_acc <= {4'd0, cpu_inst[3:0]};
            m_pc  <= m_pc + 8'd1;
        end else if (cpu_inst[5:4] == 2'b00) begin
            m_pc <= m_pc + {{4{cpu_inst[3]}}, cpu_inst[3:0]};
        end else begin
            m_pc <= m_pc + 8'd1;
        end
    end
    assign cpu_out = cpu_clk ? m_pc : m_acc;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [7:0] a, input logic [5:0] d);
        ld_valid = 1'b1; ld_addr = a; ld_data = d;
        tick(1);
        ld_valid = 1'b0;
        $display("load addr=%0d data=0x%02h", a, d);
    endtask

    task automatic wait_halt(input string tag);
        for (int k = 0; k < 100 && !halted; k++) tick(1);
        chk(tag, halted, 1);
    endtask

    initial begin
        int t0, pops, ic0, last_ic;
        logic [7:0] last_pc;
        logic [7:0] pcq[$];
        int ic_t[$];

        rst = 1; start = 0; stop = 0; step = 0; bp_en = 0; bp_addr = 0;
        ld_valid = 0; ld_addr = 0; ld_data = 0; out_ready = 0;
        tick(2);
        chk("rst_cpu_clk", cpu_clk, 0);
        chk("rst_cpu_rst", cpu_rst, 1);
        chk("rst_cpu_inst", cpu_inst, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_pc_mon", pc_mon, 0);
        chk("rst_icount", icount, 0);
        rst = 0;
        tick(1);
        chk("idle_ld_ready", ld_ready, 1);
        chk("idle_busy", busy, 0);
        chk("idle_halted", halted, 0);

        load(8'd0, 6'h15);
        load(8'd1, 6'h3B);
        load(8'd2, 6'h0F);

        // 1: free run with consumer always ready
        out_ready = 1; start = 1; tick(1); start = 0; t0 = cyc;
        chk("t1_busy", busy, 1);
        for (int k = 0; k < 40 && cpu_rst; k++) tick(1);
        chk("t1_crst_len", cyc - t0, 8);
        chk("t1_crst_inst", cpu_inst, 6'h15);
        chk("t1_crst_pc", pc_mon, 0);
        pops = 0; last_pc = pc_mon; last_ic = icount;
        for (int i = 0; i < 60; i++) begin
            tick(1);
            if (out_valid && out_ready) begin
                pops++;
                chk("t1_out_data", out_data, 8'h05);
                $display("t1 pop data=0x%02h", out_data);
            end
            if (pc_mon != last_pc) begin pcq.push_back(pc_mon); last_pc = pc_mon; end
            if (int'(icount) != last_ic) begin ic_t.push_back(cyc); last_ic = icount; end
        end
        chk("t1_pc0", pcq[0], 1);
        chk("t1_pc1", pcq[1], 2);
        chk("t1_pc2", pcq[2], 1);
        chk("t1_pc3", pcq[3], 2);
        chk("t1_period", ic_t[1] - ic_t[0], 5);
        chk("t1_pop_rate", (pops >= 5 && pops <= 7), 1);

        // 2: consumer stalls until FIFO fills, CPU freezes in low phase
        out_ready = 0;
        tick(80);
        ic0 = icount;
        tick(20);
        chk("t2_cpu_clk_low", cpu_clk, 0);
        chk("t2_pc_frozen", pc_mon, 1);
        chk("t2_icount_frozen", icount, ic0);
        chk("t2_out_valid", out_valid, 1);
        out_ready = 1; pops = 0;
        for (int i = 0; i < 30; i++) begin
            if (out_valid) begin
                pops++;
                chk("t2_drain_data", out_data, 8'h05);
                $display("t2 pop data=0x%02h", out_data);
            end
            tick(1);
        end
        chk("t2_drain_count", pops >= 5, 1);
        chk("t2_resumed", int'(icount) > ic0, 1);

        // 3: breakpoint, step, resume past breakpoint
        bp_en = 1; bp_addr = 8'd2;
        wait_halt("t3_bp_halt");
        chk("t3_bp_pc", pc_mon, 2);
        chk("t3_bp_cpu_clk", cpu_clk, 1);
        chk("t3_bp_ld_ready", ld_ready, 1);
        chk("t3_bp_inst", cpu_inst, 6'h0F);
        ic0 = icount;
        step = 1; tick(1); step = 0;
        chk("t3_step_running", halted, 0);
        wait_halt("t3_step_halt");
        chk("t3_step_pc", pc_mon, 1);
        chk("t3_step_icount", icount, 16'(ic0 + 1));
        start = 1; tick(1); start = 0;
        wait_halt("t3_resume_halt");
        chk("t3_resume_pc", pc_mon, 2);
        chk("t3_resume_icount", icount, 16'(ic0 + 4));
        $display("t3 halted pc=%0d icount=%0d", pc_mon, icount);

        // 4: stop during low phase completes exactly one instruction
        bp_en = 0; ic0 = icount;
        start = 1; tick(1); start = 0;
        stop = 1; tick(1); stop = 0;
        wait_halt("t4_stop_halt");
        chk("t4_icount", icount, 16'(ic0 + 1));
        chk("t4_pc", pc_mon, 1);
        stop = 1; tick(1); stop = 0;
        tick(10);
        chk("t4_stop_in_halt", halted, 1);
        chk("t4_icount_hold", icount, 16'(ic0 + 1));

        // 5: loader blocked while running; word written in HALT is executed by step
        bp_en = 1; bp_addr = 8'd2;
        start = 1; tick(1); start = 0;
        ld_valid = 1; ld_addr = 8'd0; ld_data = 6'h3F;
        chk("t5_ld_ready_run", ld_ready, 0);
        tick(1); ld_valid = 0;
        wait_halt("t5_bp_halt");
        chk("t5_bp_pc", pc_mon, 2);
        load(8'd1, 6'h19);
        bp_en = 0;
        step = 1; tick(1); step = 0;
        wait_halt("t5_step1_halt");
        chk("t5_new_inst", cpu_inst, 6'h19);
        step = 1; tick(1); step = 0;
        wait_halt("t5_step2_halt");
        chk("t5_step2_pc", pc_mon, 2);
        chk("t5_acc", m_acc, 8'h09);

        // 6: reset while CPU clock high
        load(8'd1, 6'h3B);
        out_ready = 0;
        start = 1; tick(1); start = 0;
        for (int k = 0; k < 60 && !out_valid; k++) tick(1);
        chk("t6_pre_out_valid", out_valid, 1);
        for (int k = 0; k < 20 && !cpu_clk; k++) tick(1);
        chk("t6_in_hi", cpu_clk, 1);
        rst = 1; tick(1); rst = 0;
        chk("t6_cpu_rst", cpu_rst, 1);
        chk("t6_cpu_clk", cpu_clk, 0);
        chk("t6_out_valid", out_valid, 0);
        chk("t6_idle", {busy, halted, ld_ready}, 3'b001);
        chk("t6_icount", icount, 0);
        out_ready = 1;
        start = 1; tick(1); start = 0;
        for (int k = 0; k < 40 && cpu_rst; k++) tick(1);
        chk("t6_ram_kept", cpu_inst, 6'h15);
        for (int k = 0; k < 40 && icount != 16'd1; k++) tick(1);
        chk("t6_first_acc", m_acc, 8'h05);
        for (int k = 0; k < 40 && !out_valid; k++) tick(1);
        chk("t6_first_out", out_data, 8'h05);
        $display("t6 restart out=0x%02h", out_data);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
